// File: rtl/iob_fifo_obuf2.sv
// Two-entry in-order output buffer: absorbs RAM read data one cycle after the read
// and presents the oldest word as the FIFO head.
module iob_fifo_obuf2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [1:0]        o_cnt,
  output logic [DATA_W-1:0] o_head
);

  logic [1:0][DATA_W-1:0] r_mem;
  logic                   r_hd;
  logic [1:0]             r_cnt;
  logic                   w_wr_idx;

  // Load lands behind the current head; with cnt==1 and a concurrent pop it becomes the new head.
  assign w_wr_idx = r_hd ^ r_cnt[0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_mem <= '0;
      r_hd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_load) r_mem[w_wr_idx] <= i_data;
      if (i_pop)  r_hd <= ~r_hd;
      case ({i_load, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt  = r_cnt;
  assign o_head = r_mem[r_hd];

endmodule

// File: rtl/iob_tiled_fifo_ctrl.sv
// FIFO controller around a single-port tiled RAM with 1-cycle registered read:
// one RAM op per cycle, write/read alternation under contention, 2-word output buffer.
module iob_tiled_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              w_valid_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_ready_o,
  output logic              r_valid_o,
  output logic [DATA_W-1:0] r_data_o,
  input  logic              r_ready_i,
  output logic [ADDR_W+1:0] level_o,
  output logic              ram_w_en_o,
  output logic              ram_r_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_w_data_o,
  input  logic [DATA_W-1:0] ram_r_data_i
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int LVL_W = ADDR_W + 2;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_ram_cnt;
  logic              r_inflight;
  logic              r_prio_rd;

  logic [1:0]        w_buf_cnt;
  logic              w_not_full, w_rd_req, w_wr, w_rd, w_pop;

  // Read only when the buffer is guaranteed a free slot for the returning word.
  assign w_not_full = r_ram_cnt < C_DEPTH;
  assign w_rd_req   = (r_ram_cnt != '0) && (({1'b0, w_buf_cnt} + {2'b00, r_inflight}) < 3'd2);
  assign w_ready_o  = w_not_full & ~(w_rd_req & r_prio_rd);
  assign w_wr       = w_valid_i & w_ready_o;
  assign w_rd       = ~w_wr & w_rd_req;
  assign w_pop      = r_valid_o & r_ready_i;

  assign ram_w_en_o   = w_wr;
  assign ram_r_en_o   = w_rd;
  assign ram_addr_o   = w_wr ? r_wr_ptr : (w_rd ? r_rd_ptr : '0);
  assign ram_w_data_o = w_wr ? w_data_i : '0;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_prio_rd  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      r_inflight <= w_rd;
      // Flip priority only when both sides actually compete for the RAM port.
      if (w_valid_i & w_not_full & w_rd_req) r_prio_rd <= ~r_prio_rd;
    end
  end

  iob_fifo_obuf2 #(.DATA_W(DATA_W)) u_obuf (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .i_load   (r_inflight),
    .i_data   (ram_r_data_i),
    .i_pop    (w_pop),
    .o_cnt    (w_buf_cnt),
    .o_head   (r_data_o)
  );

  assign r_valid_o = (w_buf_cnt != 2'd0);
  assign level_o   = {1'b0, r_ram_cnt} + LVL_W'(w_buf_cnt) + LVL_W'(r_inflight);

endmodule

// File: tb/tb_iob_tiled_fifo_ctrl.sv
// Directed bench for iob_tiled_fifo_ctrl with a behavioural 1-cycle-read RAM and an order scoreboard.
module tb_iob_tiled_fifo_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              arst_n_i = 1'b0;
  logic              w_valid_i = 1'b0;
  logic [DATA_W-1:0] w_data_i = '0;
  logic              w_ready_o;
  logic              r_valid_o;
  logic [DATA_W-1:0] r_data_o;
  logic              r_ready_i = 1'b0;
  logic [ADDR_W+1:0] level_o;
  logic              ram_w_en_o, ram_r_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_w_data_o;
  logic [DATA_W-1:0] ram_r_data_i = '0;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] sb [$];
  int n_chk = 0, n_pass = 0;
  int n_pop = 0, n_ord_err = 0, n_both = 0;

  iob_tiled_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .w_valid_i    (w_valid_i),
    .w_data_i     (w_data_i),
    .w_ready_o    (w_ready_o),
    .r_valid_o    (r_valid_o),
    .r_data_o     (r_data_o),
    .r_ready_i    (r_ready_i),
    .level_o      (level_o),
    .ram_w_en_o   (ram_w_en_o),
    .ram_r_en_o   (ram_r_en_o),
    .ram_addr_o   (ram_addr_o),
    .ram_w_data_o (ram_w_data_o),
    .ram_r_data_i (ram_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (ram_w_en_o) ram[ram_addr_o] <= ram_w_data_o;
    if (ram_r_en_o) ram_r_data_i <= ram[ram_addr_o];
  end

  // Scoreboard: handshakes are sampled mid-cycle, inputs change just after the rising edge.
  always @(negedge clk_i) begin
    if (!arst_n_i) sb.delete();
    else begin
      if (ram_w_en_o && ram_r_en_o) n_both++;
      if (w_valid_i && w_ready_o) sb.push_back(w_data_i);
      if (r_valid_o && r_ready_i) begin
        n_pop++;
        if (sb.size() == 0 || sb[0] != r_data_o) n_ord_err++;
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    int t = 0;
    w_valid_i = 1'b1;
    w_data_i  = d;
    @(negedge clk_i);
    while (!w_ready_o && t < 2000) begin @(negedge clk_i); t++; end
    if (!w_ready_o) chk("push_timeout", w_ready_o, 1);
    @(posedge clk_i); #1;
    w_valid_i = 1'b0;
  endtask

  task automatic drain_to(input int target, input int maxc);
    int t = 0;
    r_ready_i = 1'b1;
    while (int'(level_o) > target && t < maxc) begin @(posedge clk_i); #1; t++; end
    r_ready_i = 1'b0;
    if (int'(level_o) > target) chk("drain_timeout", level_o, target);
  endtask

  initial begin
    int e0, p0, t, alt_err;
    logic prev_w, acc;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_level", level_o, 0);
    chk("rst_rvalid", r_valid_o, 0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_wready", w_ready_o, 1);
    chk("idle_rvalid", r_valid_o, 0);
    chk("idle_level", level_o, 0);
    chk("idle_rdata", r_data_o, 0);
    chk("idle_strobes", {ram_w_en_o, ram_r_en_o}, 0);
    chk("idle_addr", ram_addr_o, 0);

    // single word latency
    push(16'h0020);
    chk("sw_e0_rvalid", r_valid_o, 0);
    @(negedge clk_i);
    chk("sw_rd_en", ram_r_en_o, 1);
    chk("sw_rd_addr", ram_addr_o, 0);
    @(posedge clk_i); #1;
    chk("sw_e1_rvalid", r_valid_o, 0);
    @(posedge clk_i); #1;
    chk("sw_e2_rvalid", r_valid_o, 1);
    chk("sw_e2_rdata", r_data_o, 16'h0020);
    chk("sw_e2_level", level_o, 1);
    r_ready_i = 1'b1;
    @(posedge clk_i); #1;
    r_ready_i = 1'b0;
    chk("sw_pop_level", level_o, 0);

    // fill to DEPTH+2, then take the level down to half
    e0 = n_ord_err; p0 = n_pop;
    for (int i = 0; i < DEPTH + 2; i++) push(16'(32 + i));
    repeat (3) @(posedge clk_i);
    #1;
    chk("fill_level", level_o, DEPTH + 2);
    chk("fill_wready", w_ready_o, 0);
    chk("fill_rvalid", r_valid_o, 1);
    chk("fill_head", r_data_o, 32);
    drain_to(DEPTH / 2 + 1, 20000);
    chk("half_level", level_o, DEPTH / 2 + 1);

    // contention: push and pop held high
    alt_err = 0; prev_w = 1'b0;
    w_valid_i = 1'b1; r_ready_i = 1'b1; w_data_i = 16'd9000;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk_i);
      acc = w_ready_o;
      if (c >= 12) begin
        if (ram_w_en_o == ram_r_en_o) alt_err++;
        if (c > 12 && ram_w_en_o == prev_w) alt_err++;
      end
      prev_w = ram_w_en_o;
      @(posedge clk_i); #1;
      if (acc) w_data_i = w_data_i + 16'd1;
    end
    w_valid_i = 1'b0; r_ready_i = 1'b0;
    chk("cont_alternate", alt_err, 0);
    drain_to(0, 20000);
    chk("fill_cont_order", n_ord_err - e0, 0);
    chk("fill_cont_sb_empty", sb.size(), 0);
    chk("fill_cont_level", level_o, 0);

    // pointer wrap: 3*DEPTH words, pop every other cycle
    e0 = n_ord_err; p0 = n_pop;
    fork
      begin : prod
        int cyc = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
          w_valid_i = 1'b1;
          w_data_i  = 16'h4000 + 16'(i);
          @(negedge clk_i);
          while (!w_ready_o && cyc < 60000) begin @(negedge clk_i); cyc++; end
          @(posedge clk_i); #1;
          cyc++;
        end
        w_valid_i = 1'b0;
      end
      begin : cons
        int cyc = 0;
        while ((n_pop - p0) < 3 * DEPTH && cyc < 60000) begin
          @(posedge clk_i); #1;
          r_ready_i = ~r_ready_i;
          cyc++;
        end
        r_ready_i = 1'b0;
      end
    join
    chk("wrap_pops", n_pop - p0, 3 * DEPTH);
    chk("wrap_order", n_ord_err - e0, 0);
    chk("wrap_level", level_o, 0);

    // reset while a read is in flight
    push(16'h5555);
    t = 0;
    @(negedge clk_i);
    while (!ram_r_en_o && t < 10) begin @(negedge clk_i); t++; end
    chk("mr_rd_seen", ram_r_en_o, 1);
    @(posedge clk_i); #1;
    arst_n_i = 1'b0;
    #1;
    chk("mr_rst_level", level_o, 0);
    chk("mr_rst_rvalid", r_valid_o, 0);
    repeat (2) @(negedge clk_i);
    #1;
    arst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("mr_rel_rvalid", r_valid_o, 0);
    chk("mr_rel_level", level_o, 0);
    chk("mr_rel_wready", w_ready_o, 1);
    push(16'h1234);
    t = 0;
    while (!r_valid_o && t < 10) begin @(posedge clk_i); #1; t++; end
    chk("mr_first_valid", r_valid_o, 1);
    chk("mr_first_data", r_data_o, 16'h1234);
    r_ready_i = 1'b1;
    @(posedge clk_i); #1;
    r_ready_i = 1'b0;
    chk("mr_end_level", level_o, 0);

    chk("no_dual_strobe", n_both, 0);
    chk("total_order", n_ord_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iob_tiled_fifo_ctrl.md
IOB_TILED_FIFO_CTRL -- requirements
Module: iob_tiled_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the word width.
REQ-002 SHALL have parameter ADDR_W, default 13, the RAM address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port arst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port w_valid_i, input, 1, producer word valid.
REQ-006 SHALL have port w_data_i, input, DATA_W, producer word.
REQ-007 SHALL have port w_ready_o, output, 1, word accepted when w_valid_i & w_ready_o.
REQ-008 SHALL have port r_valid_o, output, 1, head word available.
REQ-009 SHALL have port r_data_o, output, DATA_W, head word.
REQ-010 SHALL have port r_ready_i, input, 1, consumer pops when r_valid_o & r_ready_i.
REQ-011 SHALL have port level_o, output, ADDR_W+2, total words held (RAM + in-flight + output buffer).
REQ-012 SHALL have ports ram_w_en_o, ram_r_en_o (1 each), ram_addr_o (ADDR_W), ram_w_data_o (DATA_W), outputs, and ram_r_data_i (DATA_W), input, driving one tiled single-address RAM with 1-cycle registered read.

Function
REQ-013 SHALL keep ADDR_W-bit write and read pointers that wrap from DEPTH-1 to 0, plus an ADDR_W+1-bit RAM occupancy count ram_cnt.
REQ-014 SHALL issue at most one RAM operation per cycle; ram_w_en_o and ram_r_en_o SHALL never be high together.
REQ-015 SHALL define rd_req = (ram_cnt > 0) & (buf_cnt + inflight < 2), computed from registers only.
REQ-016 SHALL drive w_ready_o = (ram_cnt < DEPTH) & !(rd_req & prio_rd), registered inputs only (no path from w_valid_i).
REQ-017 SHALL perform a write (ram_w_en_o=1, ram_addr_o=wr_ptr, ram_w_data_o=w_data_i) when w_valid_i & w_ready_o; otherwise issue a read (ram_r_en_o=1, ram_addr_o=rd_ptr) when rd_req.
REQ-018 SHALL toggle prio_rd each cycle both w_valid_i & (ram_cnt<DEPTH) and rd_req are true, giving strict alternation under contention; otherwise prio_rd holds.
REQ-019 SHALL set inflight on a read cycle and, in the following cycle, write ram_r_data_i into a 2-entry in-order output buffer and clear inflight.
REQ-020 SHALL drive r_valid_o = (buf_cnt > 0) and r_data_o = oldest buffer entry, both from registers.
REQ-021 SHALL allow pop and buffer load in the same cycle, buf_cnt then unchanged.
REQ-022 SHALL give latency: word accepted at edge E0 into an empty FIFO with r_ready_i low has r_valid_o high after edge E2.
REQ-023 SHALL keep ram_cnt unchanged on a cycle with neither RAM op; increment on write; decrement on read.
REQ-024 SHALL hold level_o = ram_cnt + inflight + buf_cnt; maximum DEPTH+2.
REQ-025 SHALL drive ram_addr_o and ram_w_data_o to 0 on idle cycles.

Reset
REQ-026 SHALL, on arst_n_i low, clear pointers, ram_cnt, inflight, buf_cnt, prio_rd (write-first) immediately; r_valid_o=0, r_data_o=0, level_o=0, ram_w_en_o=ram_r_en_o=0, w_ready_o=1 after reset.
REQ-027 SHALL discard a read in flight when reset asserts mid-operation; no stale word appears after release.

Structure
REQ-028 SHALL need no shared package; DEPTH and counter widths are localparams derived from ADDR_W.
REQ-029 SHALL place the 2-entry output buffer in sub-module iob_fifo_obuf2 (load, pop, count, head data).
REQ-030 SHALL be integrated with iob_ram_t2p_tiled (DATA_W 16, ADDR_W 13, TILE_ADDR_W 11) via the ram_* ports.

Verification
REQ-031 Reset-then-idle: after release -> w_ready_o=1, r_valid_o=0, level_o=0, no RAM strobes.
REQ-032 Single word: push 0x0020 at E0, r_ready_i=0 -> r_valid_o high after E2 with r_data_o=0x0020, level_o=1.
REQ-033 Fill: push 8194 words 32..8225 with r_ready_i=0 -> w_ready_o low once ram_cnt=8192 after buffer holds 2; level_o=8194; pops return 32..8225 in order.
REQ-034 Contention: w_valid_i and r_ready_i held high, FIFO half full -> ram_w_en_o/ram_r_en_o alternate every cycle, order preserved, no loss.
REQ-035 Pointer wrap: stream 3*8192 words at 50% pop rate -> all data in order across address 8191->0.
REQ-036 Mid-read reset: assert arst_n_i in the cycle after ram_r_en_o -> after release r_valid_o=0, level_o=0, next pushed word 0x1234 is first popped.
